mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ROUND_ROBIN, default 1, meaning 1 = round-robin grant and 0 = fixed dbus-over-ibus priority.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ireq  input  ibus_req_t  CPU fetch request {valid, addr[31:0]}.
REQ-005 SHALL have port iresp  output  ibus_resp_t  fetch response {addr_ok, data_ok, data[31:0]}.
REQ-006 SHALL have port dreq  input  dbus_req_t  CPU data request {valid, addr[31:0], size msize_t, strobe[3:0], data[31:0]}.
REQ-007 SHALL have port dresp  output  dbus_resp_t  data response {addr_ok, data_ok, data[31:0]}.
REQ-008 SHALL have port creq  output  cbus_req_t  memory request {valid, is_write, size, addr, strobe, data}.
REQ-009 SHALL have port cresp  input  cbus_resp_t  memory response {okay, data[31:0]}.

Function
REQ-010 SHALL implement states IDLE, BUSY_I, BUSY_D, with IDLE entered on reset.
REQ-011 In IDLE, a valid request SHALL be granted and latched on the same edge: next state BUSY_I or BUSY_D.
REQ-012 With both valid in IDLE, the grant SHALL follow these rules:
- ROUND_ROBIN=1: grant the requester not granted last; the first contention after reset goes to dbus.
- ROUND_ROBIN=0: grant dbus.
REQ-013 The latched request SHALL drive creq while in BUSY_*, with creq.valid=1 and stable fields until completion.
REQ-014 creq.is_write SHALL equal |strobe for dbus grants and 0 for ibus grants.
REQ-015 For ibus grants, creq.size SHALL be MSIZE4 and creq.strobe SHALL be 0.
REQ-016 creq.valid SHALL be 0 in IDLE.
REQ-017 Completion is cresp.okay=1 in a BUSY_* state; the owner's addr_ok and data_ok SHALL both be 1 for exactly that cycle.
REQ-018 On completion, the owner's data output SHALL equal cresp.data, and the next state SHALL be IDLE.
REQ-019 Minimum latency SHALL be two cycles: grant edge, then okay in the first BUSY cycle.
REQ-020 A new grant SHALL occur no earlier than the cycle after completion; there is no same-edge regrant.
REQ-021 The non-owner's addr_ok and data_ok SHALL be 0 at all times.
REQ-022 The owner deasserting valid mid-transaction SHALL NOT abort the transaction; completion is still signalled and may be ignored.
REQ-023 Request fields changing after grant SHALL have no effect on creq.
REQ-024 cresp.okay in IDLE SHALL be ignored, with no state change and no response pulse.
REQ-025 iresp.data and dresp.data SHALL be 0 whenever their data_ok is 0.

Reset
REQ-026 Assertion of resetn=0 at any time, including mid-transaction, SHALL asynchronously force:
- state IDLE;
- creq all-zero;
- iresp and dresp all-zero;
- last-grant pointer = ibus.
REQ-027 After resetn rises, the first grant SHALL be possible at the first rising clk edge.
REQ-028 An in-flight transaction interrupted by reset SHALL be dropped and its later cresp.okay ignored.

Structure
REQ-029 The following SHALL live in the shared common package: ibus_req_t, ibus_resp_t, dbus_req_t, dbus_resp_t, cbus_req_t, cbus_resp_t, msize_t, and the MSIZE* constants.
REQ-030 The arbiter state enum SHALL be local to the module.
REQ-031 The module SHALL have no sub-modules; it is one FSM plus request/grant registers.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- ireq valid addr=0xBFC00000; cresp.okay after 3 cycles with data=0x3C080001 -> creq.is_write=0, size=MSIZE4; iresp addr_ok=data_ok=1 for 1 cycle with data=0x3C080001.
- dreq write addr=0x80000010, strobe=4'b0011, data=0xDEADBEEF, size=MSIZE2 -> creq.is_write=1 with exact fields held until okay; dresp pulse.
- Both valid every cycle with ROUND_ROBIN=1 and okay immediate -> grants alternate D,I,D,I; with ROUND_ROBIN=0 -> D only.
- resetn low in BUSY_D before okay -> creq.valid=0 immediately without a clock; a subsequent okay is ignored; the next ireq is served normally.
- The owner drops valid and changes addr after grant -> creq.addr is unchanged, and the completion pulse still occurs.
- cresp.okay=1 in IDLE -> no addr_ok/data_ok, state remains IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus types for the CPU-side ibus/dbus and the memory-side cbus.
// It also holds small helpers that turn a CPU request into a cbus request.
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        okay;
    logic [31:0] data;
  } cbus_resp_t;

  // Instruction fetches are always full-word reads.
  function automatic cbus_req_t f_creq_from_ireq(input ibus_req_t req);
    cbus_req_t c;
    c.valid    = 1'b1;
    c.is_write = 1'b0;
    c.size     = MSIZE4;
    c.addr     = req.addr;
    c.strobe   = 4'b0000;
    c.data     = 32'h0000_0000;
    return c;
  endfunction

  // A data access is a write exactly when any byte strobe is set.
  function automatic cbus_req_t f_creq_from_dreq(input dbus_req_t req);
    cbus_req_t c;
    c.valid    = 1'b1;
    c.is_write = |req.strobe;
    c.size     = req.size;
    c.addr     = req.addr;
    c.strobe   = req.strobe;
    c.data     = req.data;
    return c;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter: the CPU fetch bus and the CPU data bus share one
// memory bus. One transaction is in flight at a time; the winning request
// is latched on the grant edge and held on creq until the memory says okay.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  localparam logic RR_EN = (ROUND_ROBIN != 32'sd0);

  state_t    r_state;
  state_t    w_state_nxt;
  cbus_req_t r_creq;
  cbus_req_t w_creq_nxt;
  logic      r_last_d;     // 1: last grant went to dbus, 0: to ibus
  logic      w_last_d_nxt;
  logic      w_pick_d;

  // dbus wins if it is alone, if priority is fixed, or if ibus was served last.
  assign w_pick_d = dreq.valid & (~ireq.valid | ~RR_EN | ~r_last_d);

  // Next-state, latched request and last-grant pointer.
  always_comb begin
    w_state_nxt  = r_state;
    w_creq_nxt   = r_creq;
    w_last_d_nxt = r_last_d;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_d) begin
          w_state_nxt  = ST_BUSY_D;
          w_creq_nxt   = f_creq_from_dreq(dreq);
          w_last_d_nxt = 1'b1;
        end else if (ireq.valid) begin
          w_state_nxt  = ST_BUSY_I;
          w_creq_nxt   = f_creq_from_ireq(ireq);
          w_last_d_nxt = 1'b0;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        // Completion returns to IDLE; regrant waits for the next edge.
        if (cresp.okay) begin
          w_state_nxt = ST_IDLE;
          w_creq_nxt  = '0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_creq_nxt  = '0;
      end
    endcase
  end

  // State, latched request and grant pointer registers; reset drops any transfer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_creq   <= '0;
      r_last_d <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_creq   <= w_creq_nxt;
      r_last_d <= w_last_d_nxt;
    end
  end

  assign creq = r_creq;

  // Response pulse goes only to the current owner, in the okay cycle itself.
  always_comb begin
    iresp = '0;
    dresp = '0;
    if (cresp.okay && (r_state == ST_BUSY_I)) begin
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = cresp.data;
    end else if (cresp.okay && (r_state == ST_BUSY_D)) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = cresp.data;
    end else begin
      iresp = '0;
      dresp = '0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one round-robin and one fixed-priority
// instance share the same stimulus and are compared every cycle against a
// transaction-level model, plus hand-computed literal checks per scenario.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  ibus_req_t  ireq;
  dbus_req_t  dreq;
  cbus_resp_t cresp;

  ibus_resp_t iresp_rr, iresp_fp;
  dbus_resp_t dresp_rr, dresp_fp;
  cbus_req_t  creq_rr, creq_fp;

  int n_checks = 0;
  int n_fail = 0;

  // Model: owner 0 = none, 1 = ibus, 2 = dbus. Index 0 = round-robin, 1 = fixed.
  int        m_owner  [2];
  cbus_req_t m_lat    [2];
  bit        m_last_d [2];

  mem_bus_arbiter #(.ROUND_ROBIN(1)) u_rr (
    .clk(clk), .resetn(resetn), .ireq(ireq), .iresp(iresp_rr),
    .dreq(dreq), .dresp(dresp_rr), .creq(creq_rr), .cresp(cresp));

  mem_bus_arbiter #(.ROUND_ROBIN(0)) u_fp (
    .clk(clk), .resetn(resetn), .ireq(ireq), .iresp(iresp_fp),
    .dreq(dreq), .dresp(dresp_fp), .creq(creq_fp), .cresp(cresp));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic cbus_req_t exp_from_i(input ibus_req_t r);
    cbus_req_t c;
    c = '0;
    c.valid = 1'b1;
    c.size  = MSIZE4;
    c.addr  = r.addr;
    return c;
  endfunction

  function automatic cbus_req_t exp_from_d(input dbus_req_t r);
    cbus_req_t c;
    c.valid    = 1'b1;
    c.is_write = (r.strobe != 4'b0000);
    c.size     = r.size;
    c.addr     = r.addr;
    c.strobe   = r.strobe;
    c.data     = r.data;
    return c;
  endfunction

  // Who is granted from idle: 0 none, 1 ibus, 2 dbus.
  function automatic int winner(input int k);
    if (!ireq.valid && !dreq.valid) return 0;
    if (!ireq.valid) return 2;
    if (!dreq.valid) return 1;
    if (k == 1) return 2;
    return m_last_d[k] ? 1 : 2;
  endfunction

  // Transaction-level model of both instances.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 2; k++) begin
        m_owner[k]  <= 0;
        m_lat[k]    <= '0;
        m_last_d[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_owner[k] == 0) begin
          case (winner(k))
            1: begin m_owner[k] <= 1; m_lat[k] <= exp_from_i(ireq); m_last_d[k] <= 1'b0; end
            2: begin m_owner[k] <= 2; m_lat[k] <= exp_from_d(dreq); m_last_d[k] <= 1'b1; end
            default: ;
          endcase
        end else if (cresp.okay) begin
          m_owner[k] <= 0;
          m_lat[k]   <= '0;
        end
      end
    end
  end

  task automatic compare_inst(input int k, input string tag, input cbus_req_t c,
                              input ibus_resp_t ir, input dbus_resp_t dr);
    ibus_resp_t ei;
    dbus_resp_t ed;
    ei = '0;
    ed = '0;
    if (cresp.okay && m_owner[k] == 1) ei = '{addr_ok: 1'b1, data_ok: 1'b1, data: cresp.data};
    if (cresp.okay && m_owner[k] == 2) ed = '{addr_ok: 1'b1, data_ok: 1'b1, data: cresp.data};
    check({"creq_", tag}, 128'(c), 128'(m_lat[k]));
    check({"iresp_", tag}, 128'(ir), 128'(ei));
    check({"dresp_", tag}, 128'(dr), 128'(ed));
  endtask

  // Every-cycle comparison, one time unit before the rising edge.
  always @(negedge clk) begin
    #4;
    compare_inst(0, "rr", creq_rr, iresp_rr, dresp_rr);
    compare_inst(1, "fp", creq_fp, iresp_fp, dresp_fp);
  end

  localparam logic [1:0] GD = 2'b10;  // {dresp.data_ok, iresp.data_ok}
  localparam logic [1:0] GI = 2'b01;

  initial begin
    logic [1:0] rr_seq [4];
    logic [1:0] exp_rr, exp_fp;
    rr_seq = '{GD, GI, GD, GI};
    ireq  = '0;
    dreq  = '0;
    cresp = '0;
    #1 resetn = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #3;
    check("reset_creq", 128'(creq_rr), 128'd0);
    check("reset_iresp", 128'(iresp_rr), 128'd0);
    check("reset_dresp", 128'(dresp_fp), 128'd0);

    // Fetch: okay on the third busy cycle.
    @(negedge clk);
    resetn = 1'b1;
    ireq = '{valid: 1'b1, addr: 32'hBFC0_0000};
    @(negedge clk);
    ireq.valid = 1'b0;
    #3;
    check("fetch_creq", 128'(creq_rr),
          128'(cbus_req_t'{valid: 1'b1, is_write: 1'b0, size: MSIZE4,
                           addr: 32'hBFC0_0000, strobe: 4'b0000, data: 32'h0}));
    repeat (2) @(negedge clk);
    cresp = '{okay: 1'b1, data: 32'h3C08_0001};
    #3;
    check("fetch_iresp", 128'(iresp_rr),
          128'(ibus_resp_t'{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h3C08_0001}));
    check("fetch_dresp_quiet", 128'(dresp_rr), 128'd0);
    @(negedge clk);
    cresp = '0;
    #3;
    check("fetch_after_iresp", 128'(iresp_rr), 128'd0);
    check("fetch_after_valid", 128'(creq_rr.valid), 128'd0);

    // Data write, fields held until okay.
    dreq = '{valid: 1'b1, addr: 32'h8000_0010, size: MSIZE2, strobe: 4'b0011, data: 32'hDEAD_BEEF};
    @(negedge clk);
    dreq = '0;
    #3;
    check("write_creq", 128'(creq_rr),
          128'(cbus_req_t'{valid: 1'b1, is_write: 1'b1, size: MSIZE2,
                           addr: 32'h8000_0010, strobe: 4'b0011, data: 32'hDEAD_BEEF}));
    @(negedge clk);
    #3;
    check("write_creq_held", 128'(creq_rr),
          128'(cbus_req_t'{valid: 1'b1, is_write: 1'b1, size: MSIZE2,
                           addr: 32'h8000_0010, strobe: 4'b0011, data: 32'hDEAD_BEEF}));
    @(negedge clk);
    cresp = '{okay: 1'b1, data: 32'h1234_5678};
    #3;
    check("write_dresp", 128'(dresp_rr),
          128'(dbus_resp_t'{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h1234_5678}));
    check("write_iresp_quiet", 128'(iresp_rr), 128'd0);
    @(negedge clk);
    cresp = '0;

    // Okay while idle is ignored.
    @(negedge clk);
    cresp = '{okay: 1'b1, data: 32'h55AA_55AA};
    #3;
    check("idle_okay_iresp", 128'(iresp_rr), 128'd0);
    check("idle_okay_dresp", 128'(dresp_rr), 128'd0);
    @(negedge clk);
    cresp = '0;
    ireq = '{valid: 1'b1, addr: 32'h0000_0100};
    #3;
    check("idle_okay_no_grant", 128'(creq_rr.valid), 128'd0);
    @(negedge clk);
    ireq.valid = 1'b0;
    #3;
    check("idle_okay_then_grant", 128'({creq_rr.valid, creq_rr.addr}), 128'({1'b1, 32'h0000_0100}));
    @(negedge clk);
    cresp = '{okay: 1'b1, data: 32'h0000_0001};
    @(negedge clk);
    cresp = '0;

    // Owner drops valid and changes addr after grant.
    @(negedge clk);
    dreq = '{valid: 1'b1, addr: 32'h8000_1000, size: MSIZE4, strobe: 4'b0000, data: 32'h0};
    @(negedge clk);
    dreq.valid = 1'b0;
    dreq.addr  = 32'h8000_2000;
    #3;
    check("drop_addr", 128'(creq_rr.addr), 128'(32'h8000_1000));
    check("drop_is_write", 128'(creq_rr.is_write), 128'd0);
    @(negedge clk);
    dreq.addr = 32'hFFFF_FFF0;
    cresp = '{okay: 1'b1, data: 32'hCAFE_F00D};
    #3;
    check("drop_addr_late", 128'(creq_rr.addr), 128'(32'h8000_1000));
    check("drop_dresp", 128'(dresp_rr),
          128'(dbus_resp_t'{addr_ok: 1'b1, data_ok: 1'b1, data: 32'hCAFE_F00D}));
    @(negedge clk);
    cresp = '0;
    dreq = '0;

    // Contention with immediate okay, fresh from reset.
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    ireq  = '{valid: 1'b1, addr: 32'h0000_0200};
    dreq  = '{valid: 1'b1, addr: 32'h0000_0300, size: MSIZE4, strobe: 4'b1111, data: 32'h0000_00AB};
    cresp = '{okay: 1'b1, data: 32'h0000_0077};
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      #3;
      exp_rr = (i % 2 == 1) ? rr_seq[(i - 1) / 2] : 2'b00;
      exp_fp = (i % 2 == 1) ? GD : 2'b00;
      check($sformatf("rr_grant_%0d", i), 128'({dresp_rr.data_ok, iresp_rr.data_ok}), 128'(exp_rr));
      check($sformatf("fp_grant_%0d", i), 128'({dresp_fp.data_ok, iresp_fp.data_ok}), 128'(exp_fp));
    end
    @(negedge clk);
    ireq.valid = 1'b0;
    dreq.valid = 1'b0;
    @(negedge clk);
    cresp = '0;

    // Reset in the middle of a data transfer.
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    dreq = '{valid: 1'b1, addr: 32'h8000_0040, size: MSIZE4, strobe: 4'b1111, data: 32'h0000_0001};
    @(negedge clk);
    dreq.valid = 1'b0;
    #2;
    check("mid_busy_valid", 128'(creq_rr.valid), 128'd1);
    resetn = 1'b0;
    #1;
    check("async_reset_creq", 128'(creq_rr), 128'd0);
    check("async_reset_dresp", 128'(dresp_rr), 128'd0);
    @(negedge clk);
    resetn = 1'b1;
    cresp = '{okay: 1'b1, data: 32'h0000_0099};
    #3;
    check("stale_okay_dresp", 128'(dresp_rr), 128'd0);
    check("stale_okay_creq", 128'(creq_rr), 128'd0);
    @(negedge clk);
    cresp = '0;
    ireq = '{valid: 1'b1, addr: 32'hBFC0_0004};
    @(negedge clk);
    ireq.valid = 1'b0;
    #3;
    check("post_reset_fetch", 128'(creq_rr),
          128'(cbus_req_t'{valid: 1'b1, is_write: 1'b0, size: MSIZE4,
                           addr: 32'hBFC0_0004, strobe: 4'b0000, data: 32'h0}));
    @(negedge clk);
    cresp = '{okay: 1'b1, data: 32'h0000_0011};
    #3;
    check("post_reset_iresp", 128'(iresp_rr),
          128'(ibus_resp_t'{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0000_0011}));
    @(negedge clk);
    cresp = '0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
